// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter must hold 0 .. 2*DW
    function automatic int cnt_width(input int dw);
        return $clog2(2 * dw + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_DW);

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module      : seq_divider_if
// Description : Request/result handshake bundle for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if
    import div_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) ();

    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   N;
    logic              Nsigned;
    logic [DW-1:0]     D;
    logic              Dsigned;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW:0]     Q;
    logic [DW:0]       R;
    logic              div_by_zero;

    modport master (
        output in_valid, N, Nsigned, D, Dsigned, out_ready,
        input  in_ready, out_valid, Q, R, div_by_zero
    );

    modport slave (
        input  in_valid, N, Nsigned, D, Dsigned, out_ready,
        output in_ready, out_valid, Q, R, div_by_zero
    );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step on magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic [DW:0]   i_rem,
    input  logic          i_bit,
    input  logic [DW-1:0] i_dmag,
    output logic [DW:0]   o_rem,
    output logic          o_qbit
);

    logic [DW+1:0] w_cat;
    logic [DW+1:0] w_diff;

    // i_rem < i_dmag always holds, so w_cat < 2^(DW+1) and the MSB of w_diff is the borrow
    always_comb begin
        w_cat  = {i_rem, i_bit};
        w_diff = w_cat - {2'b00, i_dmag};
        o_qbit = ~w_diff[DW+1];
        o_rem  = o_qbit ? w_diff[DW:0] : w_cat[DW:0];
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Restoring signed/unsigned 2*DW by DW divider, one bit per cycle.
//               Optional SEQDIV_BYPASS_EN short-cuts N == 0 and |D| == 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int c_NW = 2 * DW;
    localparam int c_CW = cnt_width(DW);

    localparam logic [1:0] c_IDLE = 2'(IDLE);
    localparam logic [1:0] c_CALC = 2'(CALC);
    localparam logic [1:0] c_FIX  = 2'(FIX);
    localparam logic [1:0] c_DONE = 2'(DONE);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_NW-1:0] r_nq;
    logic [DW:0]     r_rem;
    logic [DW-1:0]   r_dmag;
    logic            r_q_neg;
    logic            r_r_neg;
    logic [c_NW:0]   r_q;
    logic [DW:0]     r_r;
    logic            r_dbz;
    logic            r_in_ready;

    logic            w_n_neg;
    logic            w_d_neg;
    logic [c_NW-1:0] w_n_mag;
    logic [DW-1:0]   w_d_mag;
    logic            w_accept;
    logic            w_bypass;
    logic [c_NW:0]   w_byp_q;
    logic [DW:0]     w_step_rem;
    logic            w_step_q;

    assign w_n_neg  = bus.Nsigned & bus.N[c_NW-1];
    assign w_d_neg  = bus.Dsigned & bus.D[DW-1];
    assign w_n_mag  = w_n_neg ? -bus.N : bus.N;
    assign w_d_mag  = w_d_neg ? -bus.D : bus.D;
    assign w_accept = r_in_ready & bus.in_valid;

`ifdef SEQDIV_BYPASS_EN
    logic [c_NW:0] w_n_ext;

    assign w_n_ext  = {w_n_neg, bus.N};
    assign w_bypass = (bus.N == '0) || (w_d_mag == DW'(1));
    // Negating a zero dividend is still zero, so one expression covers both trivial cases
    assign w_byp_q  = w_d_neg ? -w_n_ext : w_n_ext;
`else
    assign w_bypass = 1'b0;
    assign w_byp_q  = '0;
`endif

    div_step #(
        .DW (DW)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_nq[c_NW-1]),
        .i_dmag (r_dmag),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_nq       <= '0;
            r_rem      <= '0;
            r_dmag     <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dbz      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_q_neg    <= w_n_neg ^ w_d_neg;
                        r_r_neg    <= w_n_neg;
                        r_nq       <= w_n_mag;
                        r_dmag     <= w_d_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        if (bus.D == '0) begin
                            r_q     <= '1;
                            r_r     <= '0;
                            r_dbz   <= 1'b1;
                            r_state <= c_DONE;
                        end else if (w_bypass) begin
                            r_q     <= w_byp_q;
                            r_r     <= '0;
                            r_dbz   <= 1'b0;
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_CALC;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                c_CALC: begin
                    // Quotient bits fill r_nq from the LSB as dividend bits leave the MSB
                    r_rem <= w_step_rem;
                    r_nq  <= {r_nq[c_NW-2:0], w_step_q};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(c_NW - 1)) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_q     <= r_q_neg ? -{1'b0, r_nq} : {1'b0, r_nq};
                    r_r     <= r_r_neg ? -r_rem : r_rem;
                    r_dbz   <= 1'b0;
                    r_state <= c_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        r_state    <= c_IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = (r_state == c_DONE);
    assign bus.Q           = r_q;
    assign bus.R           = r_r;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (DW = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;
    import div_pkg::*;

    localparam int DW       = 8;
    localparam int LAT_FULL = 2 * DW + 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if #(.DW(DW)) bus ();

    seq_divider #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        bit          ns;
        logic [7:0]  d;
        bit          ds;
        logic [16:0] q;
        logic [8:0]  r;
        bit          dz;
        bit          trivial;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact integer division of the extended operands, truncating toward zero
    task automatic model(input logic [15:0] n, input bit ns, input logic [7:0] d, input bit ds,
                         output logic [16:0] q, output logic [8:0] r, output bit dz, output int lat);
        longint nv, dv, qv, rv;
        nv = ns ? longint'($signed(n)) : longint'(n);
        dv = ds ? longint'($signed(d)) : longint'(d);
        if (dv == 0) begin
            q = '1; r = '0; dz = 1'b1; lat = 1;
        end else begin
            qv = nv / dv;
            rv = nv % dv;
            q = qv[16:0]; r = rv[8:0]; dz = 1'b0; lat = LAT_FULL;
`ifdef SEQDIV_BYPASS_EN
            if (nv == 0 || dv == 1 || dv == -1) lat = 1;
`endif
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic issue(input logic [15:0] n, input bit ns, input logic [7:0] d, input bit ds);
        wait_ready();
        bus.N = n; bus.Nsigned = ns; bus.D = d; bus.Dsigned = ds;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.N = 16'($urandom); bus.D = 8'($urandom);
        bus.Nsigned = 1'($urandom); bus.Dsigned = 1'($urandom);
    endtask

    task automatic run_one(input logic [15:0] n, input bit ns, input logic [7:0] d, input bit ds,
                           output logic [16:0] q, output logic [8:0] r, output bit dz,
                           output int lat, output bit rdy_after);
        issue(n, ns, d, ds);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = bus.Q; r = bus.R; dz = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rdy_after = bus.in_ready;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [16:0] q, eq, q_hold;
        logic [8:0]  r, er, r_hold;
        bit          dz, edz, rdy;
        int          lat, elat, guard;
        logic [15:0] rn;
        logic [7:0]  rd;
        bit          rns, rds;
        bit          glitch;

        vecs[0] = '{16'd1000, 1'b0, 8'd7,   1'b0, 17'd142,    9'd6,     1'b0, 1'b0};
        vecs[1] = '{16'hFF9C, 1'b1, 8'd7,   1'b1, 17'h1FFF2,  9'h1FE,   1'b0, 1'b0};
        vecs[2] = '{16'hFC18, 1'b1, 8'hFF,  1'b0, 17'h1FFFD,  9'h115,   1'b0, 1'b0};
        vecs[3] = '{16'h8000, 1'b1, 8'hFF,  1'b1, 17'h08000,  9'h000,   1'b0, 1'b1};
        vecs[4] = '{16'd1234, 1'b0, 8'h00,  1'b0, 17'h1FFFF,  9'h000,   1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 1'b0, 8'h01,  1'b0, 17'h0FFFF,  9'h000,   1'b0, 1'b1};
        vecs[6] = '{16'h0000, 1'b1, 8'd5,   1'b0, 17'h00000,  9'h000,   1'b0, 1'b1};
        vecs[7] = '{16'hFFFF, 1'b0, 8'hFF,  1'b1, 17'h10001,  9'h000,   1'b0, 1'b1};
        vecs[8] = '{16'hFFFF, 1'b0, 8'hFF,  1'b0, 17'h00101,  9'h000,   1'b0, 1'b0};
        vecs[9] = '{16'h7FFF, 1'b1, 8'h80,  1'b1, 17'h1FF01,  9'h07F,   1'b0, 1'b0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.N = '0; bus.Nsigned = 1'b0; bus.D = '0; bus.Dsigned = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_Q", 32'(bus.Q), 32'd0);
        chk("reset_R", 32'(bus.R), 32'd0);
        chk("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].n, vecs[i].ns, vecs[i].d, vecs[i].ds, q, r, dz, lat, rdy);
            elat = vecs[i].dz ? 1 : LAT_FULL;
`ifdef SEQDIV_BYPASS_EN
            if (vecs[i].trivial) elat = 1;
`endif
            chk($sformatf("vec%0d_Q", i), 32'(q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_R", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(elat));
            chk($sformatf("vec%0d_in_ready_after", i), 32'(rdy), 32'd1);
        end

        for (int i = 0; i < 200; i++) begin
            rn  = 16'($urandom);
            rd  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            rns = 1'($urandom);
            rds = 1'($urandom);
            model(rn, rns, rd, rds, eq, er, edz, elat);
            run_one(rn, rns, rd, rds, q, r, dz, lat, rdy);
            chk($sformatf("rand%0d_Q n=%h d=%h", i, rn, rd), 32'(q), 32'(eq));
            chk($sformatf("rand%0d_R n=%h d=%h", i, rn, rd), 32'(r), 32'(er));
            chk($sformatf("rand%0d_dbz", i), 32'(dz), 32'(edz));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
        end

        // Backpressure: result must hold while out_ready stays low
        issue(16'd1000, 1'b0, 8'd7, 1'b0);
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        q_hold = bus.Q; r_hold = bus.R;
        chk("bp_Q", 32'(q_hold), 32'd142);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp_hold%0d_Q", c), 32'(bus.Q), 32'(q_hold));
            chk($sformatf("bp_hold%0d_R", c), 32'(bus.R), 32'(r_hold));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_released_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_Q_after_handshake", 32'(bus.Q), 32'd142);

        // Reset in the middle of CALC aborts the request
        issue(16'hFF9C, 1'b1, 8'd7, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        chk("abort_Q_cleared", 32'(bus.Q), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready_after", 32'(bus.in_ready), 32'd1);
        glitch = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (bus.out_valid) glitch = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_result", 32'(glitch), 32'd0);

        run_one(16'd1000, 1'b0, 8'd7, 1'b0, q, r, dz, lat, rdy);
        chk("recover_Q", 32'(q), 32'd142);
        chk("recover_R", 32'(r), 32'd6);
        chk("recover_latency", 32'(lat), 32'(LAT_FULL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
